alu_ctrl_muldiv: RTL and testbench

- Next-generation ALU control for the single-cycle/pipelined MIPS core, located in the EX stage.
- Decodes alu_op/func to alu_code like the existing ALU control, and flags illegal funcs instead of driving X.
- Adds a parametrised iterative multiply/divide engine with HI/LO registers and MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO support.
- Raises a stall when a HI/LO-dependent instruction arrives while the engine is busy.

---
 rtl/alu_ctrl_muldiv_pkg.sv | 45 ++++
 rtl/alu_ctrl_muldiv_if.sv | 26 ++
 rtl/alu_ctrl_muldiv_muldiv_iter.sv | 120 ++++++++++++
 rtl/alu_ctrl_muldiv.sv | 94 +++++++++
 tb/tb_alu_ctrl_muldiv.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_muldiv_pkg.sv
// Shared ALU control constants and the multiply/divide engine state type.
// Used by the EX-stage ALU control, the muldiv engine and the main control.
package alu_pkg;

    localparam logic [2:0] ALU_OP_MEM   = 3'b000;
    localparam logic [2:0] ALU_OP_BEQ   = 3'b001;
    localparam logic [2:0] ALU_OP_ARITH = 3'b010;
    localparam logic [2:0] ALU_OP_SLTI  = 3'b011;
    localparam logic [2:0] ALU_OP_BNE   = 3'b100;

    localparam logic [2:0] ALU_CODE_AND   = 3'b000;
    localparam logic [2:0] ALU_CODE_OR    = 3'b001;
    localparam logic [2:0] ALU_CODE_ADD   = 3'b010;
    localparam logic [2:0] ALU_CODE_SUB_N = 3'b101;
    localparam logic [2:0] ALU_CODE_SUB   = 3'b110;
    localparam logic [2:0] ALU_CODE_SLT   = 3'b111;

    localparam logic [5:0] FUNC_AND   = 6'b100100;
    localparam logic [5:0] FUNC_OR    = 6'b100101;
    localparam logic [5:0] FUNC_ADD   = 6'b100000;
    localparam logic [5:0] FUNC_ADDU  = 6'b100001;
    localparam logic [5:0] FUNC_JR    = 6'b001000;
    localparam logic [5:0] FUNC_SUB   = 6'b100010;
    localparam logic [5:0] FUNC_SLT   = 6'b101010;
    localparam logic [5:0] FUNC_MFHI  = 6'b010000;
    localparam logic [5:0] FUNC_MTHI  = 6'b010001;
    localparam logic [5:0] FUNC_MFLO  = 6'b010010;
    localparam logic [5:0] FUNC_MTLO  = 6'b010011;
    localparam logic [5:0] FUNC_MULT  = 6'b011000;
    localparam logic [5:0] FUNC_MULTU = 6'b011001;
    localparam logic [5:0] FUNC_DIV   = 6'b011010;
    localparam logic [5:0] FUNC_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_MUL  = 2'b01,
        MD_DIV  = 2'b10
    } md_state_e;

    // The eight HI/LO funcs all share the 01x0xx pattern.
    function automatic logic is_hilo_func(input logic [5:0] f);
        return (f[5:4] == 2'b01) && !f[2];
    endfunction

endpackage

// File: rtl/alu_ctrl_muldiv_if.sv
// EX-stage bus between the pipeline and the ALU control / muldiv block.
interface alu_ctrl_muldiv_if #(parameter int WIDTH = 32);

    logic             valid;
    logic [2:0]       alu_op;
    logic [5:0]       func;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [2:0]       alu_code;
    logic             illegal;
    logic             hilo_wb;
    logic [WIDTH-1:0] hilo_rdata;
    logic             stall;
    logic             busy;

    modport master (
        output valid, alu_op, func, rs_val, rt_val,
        input  alu_code, illegal, hilo_wb, hilo_rdata, stall, busy
    );

    modport slave (
        input  valid, alu_op, func, rs_val, rt_val,
        output alu_code, illegal, hilo_wb, hilo_rdata, stall, busy
    );

endinterface

// File: rtl/alu_ctrl_muldiv_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// MULDIV_SIGNED_EN enables the signed magnitude/sign-fix path.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q, acc_step, prod_fix;
    logic [WIDTH-1:0]   b_q, mag_a, mag_b, quo, rem;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic               neg_res_q, neg_rem_q, div_zero_q;
    logic               sign_a, sign_b, last;

`ifdef MULDIV_SIGNED_EN
    assign sign_a = signed_op & op_a[WIDTH-1];
    assign sign_b = signed_op & op_b[WIDTH-1];
`else
    logic unused_signed;
    assign unused_signed = signed_op;
    assign sign_a = 1'b0;
    assign sign_b = 1'b0;
`endif

    assign mag_a = sign_a ? -op_a : op_a;
    assign mag_b = sign_b ? -op_b : op_b;
    assign last  = (cnt_q == CNT_W'(WIDTH - 1));
    assign busy  = (state_q != MD_IDLE);

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, b_q};
        if (state_q == MD_DIV) begin
            if (!div_diff[WIDTH])
                acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
                acc_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // Divide by zero falls out as quotient all-ones and remainder = dividend;
    // only the signed quotient needs forcing back to all-ones.
    always_comb begin
        prod_fix = neg_res_q ? -acc_step : acc_step;
        quo      = acc_step[WIDTH-1:0];
        rem      = acc_step[2*WIDTH-1:WIDTH];
        if (state_q == MD_DIV) begin
            hi = neg_rem_q ? -rem : rem;
            lo = div_zero_q ? '1 : (neg_res_q ? -quo : quo);
        end else begin
            hi = prod_fix[2*WIDTH-1:WIDTH];
            lo = prod_fix[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (start)
                    state_d = is_div ? MD_DIV : MD_MUL;
            end
            MD_MUL, MD_DIV: begin
                if (last) begin
                    done    = 1'b1;
                    state_d = MD_IDLE;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MD_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            b_q        <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == MD_IDLE) begin
                if (start) begin
                    cnt_q      <= '0;
                    acc_q      <= {{WIDTH{1'b0}}, mag_a};
                    b_q        <= mag_b;
                    neg_res_q  <= sign_a ^ sign_b;
                    neg_rem_q  <= sign_a;
                    div_zero_q <= (op_b == '0);
                end
            end else begin
                acc_q <= acc_step;
                cnt_q <= last ? '0 : cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// EX-stage ALU control with HI/LO registers and iterative multiply/divide.
// MULDIV_SIGNED_EN enables signed MULT/DIV; otherwise they decode as illegal.
module alu_ctrl_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    alu_ctrl_muldiv_if.slave  bus
);

`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic [WIDTH-1:0] hi_q, lo_q, md_hi, md_lo;
    logic             md_busy, md_done, md_start;
    logic             hilo_instr, issue, is_arith;

    always_comb begin
        bus.alu_code = ALU_CODE_ADD;
        bus.illegal  = 1'b0;
        case (bus.alu_op)
            ALU_OP_MEM:  bus.alu_code = ALU_CODE_ADD;
            ALU_OP_BEQ:  bus.alu_code = ALU_CODE_SUB;
            ALU_OP_SLTI: bus.alu_code = ALU_CODE_SLT;
            ALU_OP_BNE:  bus.alu_code = ALU_CODE_SUB_N;
            ALU_OP_ARITH: begin
                case (bus.func)
                    FUNC_AND:  bus.alu_code = ALU_CODE_AND;
                    FUNC_OR:   bus.alu_code = ALU_CODE_OR;
                    FUNC_ADD, FUNC_ADDU, FUNC_JR,
                    FUNC_MFHI, FUNC_MTHI, FUNC_MFLO, FUNC_MTLO,
                    FUNC_MULTU, FUNC_DIVU: bus.alu_code = ALU_CODE_ADD;
                    FUNC_SUB:  bus.alu_code = ALU_CODE_SUB;
                    FUNC_SLT:  bus.alu_code = ALU_CODE_SLT;
                    FUNC_MULT, FUNC_DIV: begin
                        bus.alu_code = ALU_CODE_ADD;
                        bus.illegal  = !SIGNED_EN;
                    end
                    default:   bus.illegal = 1'b1;
                endcase
            end
            default: bus.illegal = 1'b1;
        endcase
    end

    // A stalled HI/LO instruction re-presents next cycle, so only issue
    // (side effects) when the engine is idle.
    always_comb begin
        is_arith   = bus.valid && (bus.alu_op == ALU_OP_ARITH);
        hilo_instr = is_arith && is_hilo_func(bus.func);
        bus.stall  = hilo_instr && md_busy;
        issue      = hilo_instr && !md_busy;
        md_start   = issue && ((bus.func == FUNC_MULTU) || (bus.func == FUNC_DIVU) ||
                               (SIGNED_EN && ((bus.func == FUNC_MULT) || (bus.func == FUNC_DIV))));
        bus.hilo_wb    = is_arith && ((bus.func == FUNC_MFHI) || (bus.func == FUNC_MFLO));
        bus.hilo_rdata = (bus.func == FUNC_MFHI) ? hi_q : lo_q;
        bus.busy       = md_busy;
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .start     (md_start),
        .signed_op (!bus.func[0]),
        .is_div    (bus.func[1]),
        .op_a      (bus.rs_val),
        .op_b      (bus.rt_val),
        .busy      (md_busy),
        .done      (md_done),
        .hi        (md_hi),
        .lo        (md_lo)
    );

    // MTHI/MTLO can never coincide with done: they only issue while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (md_done) begin
            hi_q <= md_hi;
            lo_q <= md_lo;
        end else if (issue && (bus.func == FUNC_MTHI)) begin
            hi_q <= bus.rs_val;
        end else if (issue && (bus.func == FUNC_MTLO)) begin
            lo_q <= bus.rs_val;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Self-checking bench for alu_ctrl_muldiv: directed cases plus random traffic
// against a cycle-level reference model of decode, stall and HI/LO results.
module tb_alu_ctrl_muldiv;

    localparam int W = 32;
`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    localparam logic [2:0] OP_ARITH = 3'b010;
    localparam logic [5:0] F_MFHI = 6'b010000, F_MTHI = 6'b010001, F_MFLO = 6'b010010,
                           F_MTLO = 6'b010011, F_MULT = 6'b011000, F_MULTU = 6'b011001,
                           F_DIV = 6'b011010, F_DIVU = 6'b011011, F_ADD = 6'b100000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_ctrl_muldiv_if #(.WIDTH(W)) bus();

    alu_ctrl_muldiv #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0]   hi_m = '0, lo_m = '0;
    logic [2*W-1:0] pend = '0;
    int             busy_left = 0;
    bit             last_stall = 1'b0;
    logic [5:0]     func_list [16] = '{6'b100100, 6'b100101, 6'b100000, 6'b100001, 6'b001000,
                                       6'b100010, 6'b101010, 6'b010000, 6'b010001, 6'b010010,
                                       6'b010011, 6'b011000, 6'b011001, 6'b011010, 6'b011011,
                                       6'b000000};

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic bit is_hilo(input logic [5:0] f);
        return f inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU};
    endfunction

    // Returns {illegal, alu_code} straight from the decode table.
    function automatic logic [3:0] ref_decode(input logic [2:0] op, input logic [5:0] f);
        case (op)
            3'b000: return 4'b0_010;
            3'b001: return 4'b0_110;
            3'b011: return 4'b0_111;
            3'b100: return 4'b0_101;
            3'b010: begin
                case (f)
                    6'b100100: return 4'b0_000;
                    6'b100101: return 4'b0_001;
                    6'b100000, 6'b100001, 6'b001000: return 4'b0_010;
                    6'b100010: return 4'b0_110;
                    6'b101010: return 4'b0_111;
                    F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULTU, F_DIVU: return 4'b0_010;
                    F_MULT, F_DIV: return SIGNED_EN ? 4'b0_010 : 4'b1_010;
                    default: return 4'b1_010;
                endcase
            end
            default: return 4'b1_010;
        endcase
    endfunction

    // Returns {HI, LO} computed with plain 64-bit arithmetic.
    function automatic logic [2*W-1:0] ref_muldiv(input bit is_div, input bit sgn,
                                                  input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb;
        logic [63:0] p;
        logic [W-1:0] q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!is_div) begin
            if (sgn) p = sa * sb;
            else     p = {32'b0, a} * {32'b0, b};
            return p;
        end
        if (b == '0) return {a, {W{1'b1}}};
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            q = W'(sa / sb);
            r = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    task automatic applyStimulus(input bit v, input logic [2:0] op, input logic [5:0] f,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
        bus.valid  = v;
        bus.alu_op = op;
        bus.func   = f;
        bus.rs_val = a;
        bus.rt_val = b;
    endtask

    // Checks the current cycle against the model, then advances one clock.
    task automatic run_cycle();
        logic [3:0] dec;
        bit hilo, stall_e, wb_e, v, r;
        logic [2:0] op;
        logic [5:0] f;
        logic [W-1:0] a, b;
        #1;
        v = bus.valid; op = bus.alu_op; f = bus.func; a = bus.rs_val; b = bus.rt_val; r = rst;
        dec     = ref_decode(op, f);
        hilo    = v && op == OP_ARITH && is_hilo(f);
        stall_e = hilo && (busy_left > 0);
        wb_e    = v && op == OP_ARITH && (f == F_MFHI || f == F_MFLO);
        checkOutput("alu_code", bus.alu_code, dec[2:0]);
        checkOutput("illegal", bus.illegal, dec[3]);
        checkOutput("busy", bus.busy, busy_left > 0);
        checkOutput("stall", bus.stall, stall_e);
        checkOutput("hilo_wb", bus.hilo_wb, wb_e);
        if (wb_e && !stall_e)
            checkOutput("hilo_rdata", bus.hilo_rdata, (f == F_MFHI) ? hi_m : lo_m);
        last_stall = stall_e;
        @(posedge clk);
        if (r) begin
            hi_m = '0; lo_m = '0; busy_left = 0;
        end else begin
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) {hi_m, lo_m} = pend;
            end
            if (hilo && !stall_e) begin
                if (f == F_MTHI) hi_m = a;
                if (f == F_MTLO) lo_m = a;
                if (f == F_MULTU || f == F_DIVU || (SIGNED_EN && (f == F_MULT || f == F_DIV))) begin
                    pend = ref_muldiv(f[1], !f[0], a, b);
                    busy_left = W;
                end
            end
        end
        #1;
    endtask

    task automatic wait_idle();
        applyStimulus(0, 3'b000, 6'b0, '0, '0);
        while (busy_left > 0) run_cycle();
    endtask

    task automatic expect_read(input logic [5:0] f, input logic [W-1:0] exp, input string tag);
        applyStimulus(1, OP_ARITH, f, '0, '0);
        #1;
        checkOutput(tag, bus.hilo_rdata, exp);
        run_cycle();
    endtask

    task automatic directed_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input string tag);
        applyStimulus(1, OP_ARITH, F_MTHI, 32'hA5A5, '0); run_cycle();
        applyStimulus(1, OP_ARITH, F_MTLO, 32'h5A5A, '0); run_cycle();
        applyStimulus(1, OP_ARITH, f, a, b);
        run_cycle();
        wait_idle();
        expect_read(F_MFHI, exp_hi, {tag, "_hi"});
        expect_read(F_MFLO, exp_lo, {tag, "_lo"});
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'h1;
            2: return '1;
            3: return 32'h8000_0000;
            4: return W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int stalls, guard;
        applyStimulus(0, 3'b000, 6'b0, '0, '0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_cycle();
        rst = 1'b0;
        expect_read(F_MFHI, 32'h0, "reset_hi");
        expect_read(F_MFLO, 32'h0, "reset_lo");

        for (int op = 0; op < 8; op++)
            for (int i = 0; i < 16; i++) begin
                applyStimulus(0, 3'(op), func_list[i], '0, '0);
                run_cycle();
            end
        applyStimulus(0, 3'b111, F_ADD, '0, '0);
        #1;
        checkOutput("op7_illegal", bus.illegal, 1'b1);
        checkOutput("op7_code", bus.alu_code, 3'b010);
        applyStimulus(1, OP_ARITH, 6'b000000, '0, '0);
        #1;
        checkOutput("func0_illegal", bus.illegal, 1'b1);
        checkOutput("func0_code", bus.alu_code, 3'b010);
        run_cycle();

        applyStimulus(1, OP_ARITH, F_MULTU, 32'hFFFF_FFFF, 32'h2);
        run_cycle();
        applyStimulus(1, OP_ARITH, F_MFHI, '0, '0);
        stalls = 0;
        guard = 0;
        do begin
            run_cycle();
            if (last_stall) stalls++;
            guard++;
        end while (last_stall && guard < 100);
        checkOutput("mfhi_stall_cycles", 64'(stalls), 64'd32);
        expect_read(F_MFHI, 32'h1, "multu_hi");
        expect_read(F_MFLO, 32'hFFFF_FFFE, "multu_lo");

        directed_md(F_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, "divu_by0");
        directed_md(F_MULT, 32'hFFFF_FFFD, 32'd5,
                    SIGNED_EN ? 32'hFFFF_FFFF : 32'hA5A5, SIGNED_EN ? 32'hFFFF_FFF1 : 32'h5A5A, "mult");
        directed_md(F_DIV, 32'hFFFF_FFF9, 32'd2,
                    SIGNED_EN ? 32'hFFFF_FFFF : 32'hA5A5, SIGNED_EN ? 32'hFFFF_FFFD : 32'h5A5A, "div");
        directed_md(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                    SIGNED_EN ? 32'h0 : 32'hA5A5, SIGNED_EN ? 32'h8000_0000 : 32'h5A5A, "div_min");
        directed_md(F_DIV, 32'hFFFF_FFF7, 32'd0,
                    SIGNED_EN ? 32'hFFFF_FFF7 : 32'hA5A5, SIGNED_EN ? 32'hFFFF_FFFF : 32'h5A5A, "div_by0");

        applyStimulus(1, OP_ARITH, F_MTLO, 32'h1234, '0);
        run_cycle();
        applyStimulus(1, OP_ARITH, F_MFLO, '0, '0);
        #1;
        checkOutput("mtlo_rdata", bus.hilo_rdata, 32'h1234);
        checkOutput("mtlo_wb", bus.hilo_wb, 1'b1);
        checkOutput("mtlo_stall", bus.stall, 1'b0);
        run_cycle();

        applyStimulus(1, OP_ARITH, F_MULTU, 32'd123, 32'd456);
        run_cycle();
        applyStimulus(1, OP_ARITH, F_ADD, 32'd1, 32'd2);
        #1;
        checkOutput("add_busy", bus.busy, 1'b1);
        checkOutput("add_no_stall", bus.stall, 1'b0);
        run_cycle();
        wait_idle();
        expect_read(F_MFLO, 32'd56088, "multu_small_lo");

        applyStimulus(1, OP_ARITH, F_DIVU, 32'd1000, 32'd7);
        run_cycle();
        applyStimulus(0, 3'b000, 6'b0, '0, '0);
        repeat (10) run_cycle();
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        checkOutput("rst_busy", bus.busy, 1'b0);
        expect_read(F_MFHI, 32'h0, "rst_hi");
        expect_read(F_MFLO, 32'h0, "rst_lo");
        applyStimulus(1, OP_ARITH, F_MULTU, 32'h10001, 32'h10001);
        run_cycle();
        wait_idle();
        expect_read(F_MFHI, 32'h1, "post_rst_hi");
        expect_read(F_MFLO, 32'h0002_0001, "post_rst_lo");

        for (int n = 0; n < 600; n++) begin
            logic [2:0] op;
            logic [5:0] f;
            int idx;
            op  = ($urandom_range(0, 9) < 6) ? OP_ARITH : 3'($urandom_range(0, 7));
            idx = $urandom_range(0, 16);
            f   = (idx < 16) ? func_list[idx] : 6'($urandom);
            applyStimulus($urandom_range(0, 9) != 0, op, f, rand_operand(), rand_operand());
            run_cycle();
        end
        wait_idle();
        expect_read(F_MFHI, hi_m, "final_hi");
        expect_read(F_MFLO, lo_m, "final_lo");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
